// File: rtl/ram_r_pkg.sv
// Shared constants for the image-pipeline Avalon burst masters (read and write side)
// and the ram_r request FSM state encoding.
package ram_r_pkg;

  localparam int DATA_W_C          = 32'd32;
  localparam int ADDR_W_C          = 32'd32;
  localparam int BE_W_C            = 32'd4;
  localparam int BURST_LEN_R       = 32'd32;
  localparam int BURST_CNT_W_R     = 32'd6;
  localparam int FIFO_DEPTH_LOG2_C = 32'd8;
  localparam int FIFO_DEPTH_C      = 32'd256;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } ram_r_state_e;

endpackage

// File: rtl/ram_r_if.sv
// Avalon-MM burst read bus between ram_r (master) and the external RAM (slave).
interface ram_r_if import ram_r_pkg::*; #(
  parameter int DATA_WIDTH        = DATA_W_C,
  parameter int ADD_WIDTH         = ADDR_W_C,
  parameter int BYTE_ENABLE_WIDTH = BE_W_C,
  parameter int BURST_WIDTH_R     = BURST_CNT_W_R
);

  logic [ADD_WIDTH-1:0]         ram_r_address;
  logic                         ram_r_waitrequest;
  logic [BYTE_ENABLE_WIDTH-1:0] ram_r_byteenable;
  logic                         ram_r_read;
  logic [DATA_WIDTH-1:0]        ram_r_readdata;
  logic                         ram_r_readdatavalid;
  logic [BURST_WIDTH_R-1:0]     ram_r_burstcount;

  modport master (
    output ram_r_address, ram_r_byteenable, ram_r_read, ram_r_burstcount,
    input  ram_r_waitrequest, ram_r_readdata, ram_r_readdatavalid
  );

  modport slave (
    input  ram_r_address, ram_r_byteenable, ram_r_read, ram_r_burstcount,
    output ram_r_waitrequest, ram_r_readdata, ram_r_readdatavalid
  );

endinterface

// File: rtl/ram_r_fifo.sv
// Synchronous show-ahead FIFO with synchronous clear; head word, valid and usedw are
// all registered, so a push at cycle t is visible at the output in cycle t+1.
module ram_r_fifo import ram_r_pkg::*; #(
  parameter int WIDTH      = DATA_W_C,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_C,
  parameter int DEPTH      = FIFO_DEPTH_C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  valid,
  output logic [DEPTH_LOG2:0]   usedw
);

  localparam logic [DEPTH_LOG2:0] FULL_C = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   usedw_q, usedw_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic                  valid_q, valid_d;
  logic                  push_ok_s, pop_ok_s;

  // Next-state pointers, occupancy and the prefetched head word
  always_comb begin
    pop_ok_s  = pop & valid_q;
    push_ok_s = push & ~clr & ((usedw_q != FULL_C) | pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usedw_d   = usedw_q;
    head_d    = head_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + 1'b1;
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   usedw_d = usedw_q + 1'b1;
        2'b01:   usedw_d = usedw_q - 1'b1;
        default: usedw_d = usedw_q;
      endcase
      // The word being written this cycle bypasses the array when it becomes the head
      if (push_ok_s && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
      else                                     head_d = mem_q[rd_ptr_d];
    end
    valid_d = (usedw_d != '0);
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= wdata;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign rdata = head_q;
  assign valid = valid_q;
  assign usedw = usedw_q;

endmodule

// File: rtl/ram_r.sv
// Avalon-MM burst read master: fetches n_burst fixed-length bursts into a show-ahead FIFO.
// Optional macro RAM_R_BYTESWAP_EN reverses the byte order of each stored word.
module ram_r import ram_r_pkg::*; #(
  parameter int DATA_WIDTH        = DATA_W_C,
  parameter int ADD_WIDTH         = ADDR_W_C,
  parameter int BYTE_ENABLE_WIDTH = BE_W_C,
  parameter int MAX_BURST_COUNT_R = BURST_LEN_R,
  parameter int BURST_WIDTH_R     = BURST_CNT_W_R,
  parameter int FIFO_DEPTH_LOG2   = FIFO_DEPTH_LOG2_C,
  parameter int FIFO_DEPTH        = FIFO_DEPTH_C
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ram_r_if.master                    bus,
  input  logic                       start_fifo_in,
  input  logic [ADD_WIDTH-1:0]       address_fifo_in,
  input  logic [DATA_WIDTH-1:0]      n_burst_fifo_in,
  output logic [DATA_WIDTH-1:0]      data_fifo_in,
  output logic                       valid_fifo_in,
  input  logic                       ready_fifo_in,
  output logic                       bussy_fifo_in,
  output logic [FIFO_DEPTH_LOG2:0]   usedw_fifo_in
);

  localparam int                   CNT_W       = FIFO_DEPTH_LOG2 + 1;
  localparam int                   CREDIT_W    = CNT_W + 2;
  localparam logic [CNT_W-1:0]     BURST_C     = CNT_W'(MAX_BURST_COUNT_R);
  localparam logic [CNT_W-1:0]     ONE_C       = CNT_W'(1'b1);
  localparam logic [CREDIT_W-1:0]  BURST_CR_C  = CREDIT_W'(MAX_BURST_COUNT_R);
  localparam logic [CREDIT_W-1:0]  DEPTH_CR_C  = CREDIT_W'(FIFO_DEPTH);
  localparam logic [ADD_WIDTH-1:0] ADDR_STEP_C = ADD_WIDTH'(MAX_BURST_COUNT_R * BYTE_ENABLE_WIDTH);

  ram_r_state_e          state_q, state_d;
  logic                  read_q, read_d;
  logic [ADD_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0] bursts_left_q, bursts_left_d;
  logic [CNT_W-1:0]      pending_q, pending_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic                  bussy_q, bussy_d;

  logic                  accept_s, keep_s, credit_s, push_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] fifo_rdata_s;
  logic                  fifo_valid_s;
  logic [CNT_W-1:0]      fifo_usedw_s;

`ifdef RAM_R_BYTESWAP_EN
  function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < BYTE_ENABLE_WIDTH; i++) begin
      r[8*i +: 8] = w[8*(BYTE_ENABLE_WIDTH-1-i) +: 8];
    end
    return r;
  endfunction
`endif

  // Request FSM, outstanding-word accounting and busy status
  always_comb begin
    accept_s = read_q & ~bus.ram_r_waitrequest;
    keep_s   = bus.ram_r_readdatavalid & (drop_q == '0);
    credit_s = (({2'b00, fifo_usedw_s} + {2'b00, pending_q} + BURST_CR_C) <= DEPTH_CR_C);
    push_s   = keep_s & ~start_fifo_in;
    state_d       = state_q;
    read_d        = read_q;
    address_d     = address_q;
    bursts_left_d = bursts_left_q;
    pending_d     = pending_q;
    drop_d        = drop_q;
    if (start_fifo_in) begin
      state_d       = IDLE;
      read_d        = 1'b0;
      address_d     = address_fifo_in;
      bursts_left_d = n_burst_fifo_in;
      pending_d     = '0;
      // A word landing in the start cycle is itself stale, so it leaves the outstanding count
      if (bus.ram_r_readdatavalid && ((drop_q | pending_q) != '0)) drop_d = drop_q + pending_q - ONE_C;
      else                                                         drop_d = drop_q + pending_q;
    end else begin
      case (state_q)
        IDLE: begin
          if ((bursts_left_q != '0) && credit_s) begin
            state_d = REQ;
            read_d  = 1'b1;
          end else begin
            state_d = IDLE;
            read_d  = 1'b0;
          end
        end
        REQ: begin
          if (accept_s) begin
            state_d       = IDLE;
            read_d        = 1'b0;
            bursts_left_d = bursts_left_q - DATA_WIDTH'(1'b1);
            address_d     = address_q + ADDR_STEP_C;
          end else begin
            state_d = REQ;
            read_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          read_d  = 1'b0;
        end
      endcase
      pending_d = pending_q + (accept_s ? BURST_C : '0) - (keep_s ? ONE_C : '0);
      if (bus.ram_r_readdatavalid && (drop_q != '0)) drop_d = drop_q - ONE_C;
      else                                           drop_d = drop_q;
    end
    bussy_d = (bursts_left_d != '0) | (pending_d != '0) | (drop_d != '0);
  end

  // Byte-order selection for stored words
  always_comb begin
`ifdef RAM_R_BYTESWAP_EN
    wdata_s = byte_swap(bus.ram_r_readdata);
`else
    wdata_s = bus.ram_r_readdata;
`endif
  end

  // Master state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      read_q        <= 1'b0;
      address_q     <= '0;
      bursts_left_q <= '0;
      pending_q     <= '0;
      drop_q        <= '0;
      bussy_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_q        <= read_d;
      address_q     <= address_d;
      bursts_left_q <= bursts_left_d;
      pending_q     <= pending_d;
      drop_q        <= drop_d;
      bussy_q       <= bussy_d;
    end
  end

  ram_r_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fifo_in),
    .push  (push_s),
    .wdata (wdata_s),
    .pop   (ready_fifo_in),
    .rdata (fifo_rdata_s),
    .valid (fifo_valid_s),
    .usedw (fifo_usedw_s)
  );

  assign bus.ram_r_address    = address_q;
  assign bus.ram_r_read       = read_q;
  assign bus.ram_r_byteenable = '1;
  assign bus.ram_r_burstcount = BURST_WIDTH_R'(MAX_BURST_COUNT_R);
  assign data_fifo_in         = fifo_rdata_s;
  assign valid_fifo_in        = fifo_valid_s;
  assign bussy_fifo_in        = bussy_q;
  assign usedw_fifo_in        = fifo_usedw_s;

endmodule

// File: tb/tb_ram_r.sv
// Directed bench for ram_r: a simple Avalon burst slave returns incrementing words,
// and popped words / accepted addresses are logged and compared to hand-computed values.
module tb_ram_r;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] addr_in;
  logic [31:0] nb_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready;
  logic        bussy;
  logic [8:0]  usedw;

  always #5 clk = ~clk;

  ram_r_if bus_if ();

  ram_r dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus_if),
    .start_fifo_in   (start),
    .address_fifo_in (addr_in),
    .n_burst_fifo_in (nb_in),
    .data_fifo_in    (data_out),
    .valid_fifo_in   (valid_out),
    .ready_fifo_in   (ready),
    .bussy_fifo_in   (bussy),
    .usedw_fifo_in   (usedw)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ret_cnt = 0;
  int          rdv_budget = -1;
  int          wr_hold = 0;
  logic [31:0] data_ctr = 32'h0;
  logic [31:0] acc_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] pop_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef RAM_R_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Slave and consumer: decisions at negedge apply at the following posedge
  initial begin
    bus_if.ram_r_waitrequest   = 1'b0;
    bus_if.ram_r_readdatavalid = 1'b0;
    bus_if.ram_r_readdata      = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ret_cnt = 0;
        bus_if.ram_r_readdatavalid = 1'b0;
        bus_if.ram_r_waitrequest   = 1'b0;
      end else begin
        if (ret_cnt > 0 && rdv_budget != 0) begin
          bus_if.ram_r_readdatavalid = 1'b1;
          bus_if.ram_r_readdata      = data_ctr;
          data_ctr = data_ctr + 32'd1;
          ret_cnt--;
          if (rdv_budget > 0) rdv_budget--;
        end else begin
          bus_if.ram_r_readdatavalid = 1'b0;
        end
        if (bus_if.ram_r_read) begin
          rd_addr_q.push_back(bus_if.ram_r_address);
          if (wr_hold > 0) begin
            bus_if.ram_r_waitrequest = 1'b1;
            wr_hold--;
          end else begin
            bus_if.ram_r_waitrequest = 1'b0;
            acc_q.push_back(bus_if.ram_r_address);
            ret_cnt += 32;
          end
        end else begin
          bus_if.ram_r_waitrequest = 1'b0;
        end
        if (valid_out && ready) pop_q.push_back(data_out);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] n);
    start   = 1'b1;
    addr_in = a;
    nb_in   = n;
    tick();
    start   = 1'b0;
  endtask

  task automatic clear_logs();
    pop_q.delete();
    acc_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    int cnt = 0;
    while (pop_q.size() < n && cnt < budget) begin
      tick();
      cnt++;
    end
    check_val({tag, "_count"}, 32'(pop_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int cnt = 0;
    while ((bussy || valid_out) && cnt < budget) begin
      tick();
      cnt++;
    end
    check_val({tag, "_idle"}, 32'(bussy), 32'd0);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] base, input int n);
    int bad = -1;
    int lim;
    int idx;
    lim = (pop_q.size() < n) ? pop_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      if (bad < 0 && pop_q[i] !== exp_word(base + 32'(i))) bad = i;
    end
    idx = (bad < 0) ? 0 : bad;
    if (lim > 0) check_val({tag, "_seq"}, pop_q[idx], exp_word(base + 32'(idx)));
    else         check_val({tag, "_seq_empty"}, 32'(lim), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; addr_in = 32'h0; nb_in = 32'h0; ready = 1'b0;
    tick(3);
    check_val("rst_read",  32'(bus_if.ram_r_read), 32'd0);
    check_val("rst_addr",  bus_if.ram_r_address, 32'h0);
    check_val("rst_valid", 32'(valid_out), 32'd0);
    check_val("rst_bussy", 32'(bussy), 32'd0);
    check_val("rst_usedw", 32'(usedw), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: two bursts, zero-wait slave, consumer always ready
    clear_logs(); data_ctr = 32'h0; ready = 1'b1;
    do_start(32'h1000, 32'd2);
    check_val("t1_bussy_up", 32'(bussy), 32'd1);
    check_val("t1_burstcount", 32'(bus_if.ram_r_burstcount), 32'd32);
    check_val("t1_byteenable", 32'(bus_if.ram_r_byteenable), 32'hF);
    wait_pops("t1", 64, 600);
    wait_idle("t1", 50);
    check_val("t1_nacc", 32'(acc_q.size()), 32'd2);
    check_val("t1_addr0", acc_q[0], 32'h1000);
    check_val("t1_addr1", acc_q[1], 32'h1080);
    check_seq("t1", 32'h0, 64);

    // 2: waitrequest held for 5 cycles on a single request
    clear_logs(); data_ctr = 32'h0; wr_hold = 5;
    do_start(32'h1000, 32'd1);
    wait_pops("t2", 32, 300);
    wait_idle("t2", 50);
    check_val("t2_read_cycles", 32'(rd_addr_q.size()), 32'd6);
    for (int i = 0; i < rd_addr_q.size(); i++) check_val("t2_addr_stable", rd_addr_q[i], 32'h1000);
    check_val("t2_nacc", 32'(acc_q.size()), 32'd1);
    check_seq("t2", 32'h0, 32);

    // 3: credit limit with a stalled consumer
    clear_logs(); data_ctr = 32'h0; ready = 1'b0;
    do_start(32'h0, 32'd10);
    tick(600);
    check_val("t3_nacc_stall", 32'(acc_q.size()), 32'd8);
    check_val("t3_usedw_full", 32'(usedw), 32'd256);
    check_val("t3_bussy", 32'(bussy), 32'd1);
    check_val("t3_valid", 32'(valid_out), 32'd1);
    ready = 1'b1;
    wait_pops("t3", 320, 3000);
    wait_idle("t3", 50);
    check_val("t3_nacc_total", 32'(acc_q.size()), 32'd10);
    check_val("t3_addr9", acc_q[9], 32'h480);
    check_seq("t3", 32'h0, 320);

    // 4: restart with 20 words still outstanding
    clear_logs(); ready = 1'b0; data_ctr = 32'h100; rdv_budget = 12;
    do_start(32'h4000, 32'd1);
    cnt = 0;
    while (usedw != 9'd12 && cnt < 300) begin
      tick();
      cnt++;
    end
    tick(5);
    check_val("t4_usedw_before", 32'(usedw), 32'd12);
    do_start(32'h8000, 32'd1);
    check_val("t4_usedw_after", 32'(usedw), 32'd0);
    check_val("t4_valid_after", 32'(valid_out), 32'd0);
    check_val("t4_bussy_after", 32'(bussy), 32'd1);
    pop_q.delete();
    rdv_budget = -1; ready = 1'b1;
    wait_pops("t4", 32, 400);
    wait_idle("t4", 50);
    tick(10);
    check_val("t4_first", pop_q[0], exp_word(32'h120));
    check_seq("t4", 32'h120, 32);
    check_val("t4_no_extra", 32'(pop_q.size()), 32'd32);
    check_val("t4_addr_new", acc_q[acc_q.size()-1], 32'h8000);

    // 5: reset in the middle of a transfer, then a normal job
    clear_logs(); data_ctr = 32'h0; ready = 1'b1;
    do_start(32'h1000, 32'd2);
    cnt = 0;
    while (pop_q.size() < 10 && cnt < 200) begin
      tick();
      cnt++;
    end
    rst_n = 1'b0;
    tick();
    check_val("t5_read",  32'(bus_if.ram_r_read), 32'd0);
    check_val("t5_addr",  bus_if.ram_r_address, 32'h0);
    check_val("t5_valid", 32'(valid_out), 32'd0);
    check_val("t5_bussy", 32'(bussy), 32'd0);
    check_val("t5_usedw", 32'(usedw), 32'd0);
    rst_n = 1'b1;
    tick();
    clear_logs(); data_ctr = 32'h500;
    do_start(32'h2000, 32'd1);
    wait_pops("t5", 32, 300);
    wait_idle("t5", 50);
    check_val("t5_nacc", 32'(acc_q.size()), 32'd1);
    check_val("t5_addr_new", acc_q[0], 32'h2000);
    check_seq("t5", 32'h500, 32);

    // 6: zero-length job, then byte order check
    clear_logs();
    do_start(32'h3000, 32'd0);
    check_val("t6_bussy0", 32'(bussy), 32'd0);
    tick(50);
    check_val("t6_no_read", 32'(rd_addr_q.size()), 32'd0);
    check_val("t6_bussy_end", 32'(bussy), 32'd0);
    clear_logs(); data_ctr = 32'h11223344;
    do_start(32'h3000, 32'd1);
    wait_pops("t6", 32, 300);
    wait_idle("t6", 50);
`ifdef RAM_R_BYTESWAP_EN
    check_val("t6_swap", pop_q[0], 32'h44332211);
`else
    check_val("t6_noswap", pop_q[0], 32'h11223344);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
